// File: rtl/alu_reservation_station.sv
// Integer ALU issue queue: holds dispatched micro-ops, captures CDB broadcasts and presents
// the oldest entry with both operands resolved to the combinational ALU stage.
package alu_rs_pkg;
    typedef enum logic [3:0] {
        alu_add, alu_sub, alu_sll, alu_slt, alu_sltu,
        alu_xor, alu_srl, alu_sra, alu_or, alu_and
    } alu_ops;
endpackage

module alu_reservation_station
    import alu_rs_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 6,
    parameter int unsigned ROB_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  alu_ops           disp_alu_op,
    input  logic             disp_bypass,
    input  logic [ROB_W-1:0] disp_rob_idx,
    input  logic [TAG_W-1:0] disp_pd,
    input  logic             disp_s1_rdy,
    input  logic [TAG_W-1:0] disp_s1_tag,
    input  logic [31:0]      disp_s1_val,
    input  logic             disp_s2_rdy,
    input  logic [TAG_W-1:0] disp_s2_tag,
    input  logic [31:0]      disp_s2_val,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             iss_valid,
    input  logic             iss_ready,
    output alu_ops           iss_alu_op,
    output logic             iss_bypass,
    output logic [31:0]      iss_in_a,
    output logic [31:0]      iss_in_b,
    output logic [ROB_W-1:0] iss_rob_idx,
    output logic [TAG_W-1:0] iss_pd
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] valid_q;
    alu_ops           op_q     [DEPTH];
    logic [DEPTH-1:0] bypass_q;
    logic [ROB_W-1:0] rob_q    [DEPTH];
    logic [TAG_W-1:0] pd_q     [DEPTH];
    logic [DEPTH-1:0] s1_rdy_q;
    logic [DEPTH-1:0] s2_rdy_q;
    logic [TAG_W-1:0] s1_tag_q [DEPTH];
    logic [TAG_W-1:0] s2_tag_q [DEPTH];
    logic [31:0]      s1_val_q [DEPTH];
    logic [31:0]      s2_val_q [DEPTH];
    // older_q[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0] older_q  [DEPTH];

    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] blocked;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] free_idx;
    logic             disp_fire;
    logic             iss_fire;
    logic             s1_hit;
    logic             s2_hit;

    always_comb begin
        ready    = valid_q & s1_rdy_q & s2_rdy_q;
        blocked  = '0;
        sel_idx  = '0;
        free_idx = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ready[i] && older_q[i][j]) begin
                    blocked[j] = 1'b1;
                end
            end
        end
        // Exactly one ready entry has no older ready entry: the age order is total.
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (ready[j] && !blocked[j]) begin
                sel_idx = IDX_W'(j);
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign disp_ready  = ~&valid_q;
    assign disp_fire   = disp_valid && disp_ready && !flush;
    assign iss_valid   = |ready && !flush;
    assign iss_fire    = iss_valid && iss_ready;
    assign s1_hit      = cdb_valid && !disp_s1_rdy && (disp_s1_tag == cdb_tag);
    assign s2_hit      = cdb_valid && !disp_s2_rdy && (disp_s2_tag == cdb_tag);

    assign iss_alu_op  = op_q[sel_idx];
    assign iss_bypass  = bypass_q[sel_idx];
    assign iss_in_a    = s1_val_q[sel_idx];
    assign iss_in_b    = s2_val_q[sel_idx];
    assign iss_rob_idx = rob_q[sel_idx];
    assign iss_pd      = pd_q[sel_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            bypass_q <= '0;
            s1_rdy_q <= '0;
            s2_rdy_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                op_q[i]     <= alu_add;
                rob_q[i]    <= '0;
                pd_q[i]     <= '0;
                s1_tag_q[i] <= '0;
                s2_tag_q[i] <= '0;
                s1_val_q[i] <= '0;
                s2_val_q[i] <= '0;
                older_q[i]  <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && cdb_valid) begin
                    if (!s1_rdy_q[i] && s1_tag_q[i] == cdb_tag) begin
                        s1_rdy_q[i] <= 1'b1;
                        s1_val_q[i] <= cdb_data;
                    end
                    if (!s2_rdy_q[i] && s2_tag_q[i] == cdb_tag) begin
                        s2_rdy_q[i] <= 1'b1;
                        s2_val_q[i] <= cdb_data;
                    end
                end
            end
            if (iss_fire) begin
                valid_q[sel_idx] <= 1'b0;
            end
            if (disp_fire) begin
                valid_q[free_idx]  <= 1'b1;
                op_q[free_idx]     <= disp_alu_op;
                bypass_q[free_idx] <= disp_bypass;
                rob_q[free_idx]    <= disp_rob_idx;
                pd_q[free_idx]     <= disp_pd;
                s1_rdy_q[free_idx] <= disp_s1_rdy || s1_hit;
                s2_rdy_q[free_idx] <= disp_s2_rdy || s2_hit;
                s1_tag_q[free_idx] <= disp_s1_tag;
                s2_tag_q[free_idx] <= disp_s2_tag;
                s1_val_q[free_idx] <= s1_hit ? cdb_data : disp_s1_val;
                s2_val_q[free_idx] <= s2_hit ? cdb_data : disp_s2_val;
                // New entry is younger than every live entry, older than none.
                older_q[free_idx]  <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (IDX_W'(i) != free_idx) begin
                        older_q[i][free_idx] <= valid_q[i];
                    end
                end
            end
        end
    end

    disp_when_full_a : assert property (@(posedge clk) disable iff (rst)
        disp_fire |-> disp_ready);
    iss_payload_known_a : assert property (@(posedge clk) disable iff (rst)
        iss_valid |-> !$isunknown({iss_alu_op, iss_bypass, iss_in_a, iss_in_b,
                                   iss_rob_idx, iss_pd}));

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios with literal expectations plus a
// randomized run compared every cycle against an age-ordered queue model.
module tb_alu_reservation_station;
    import alu_rs_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    alu_ops      disp_alu_op;
    logic        disp_bypass;
    logic [4:0]  disp_rob_idx;
    logic [5:0]  disp_pd;
    logic        disp_s1_rdy;
    logic [5:0]  disp_s1_tag;
    logic [31:0] disp_s1_val;
    logic        disp_s2_rdy;
    logic [5:0]  disp_s2_tag;
    logic [31:0] disp_s2_val;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        iss_valid;
    logic        iss_ready;
    alu_ops      iss_alu_op;
    logic        iss_bypass;
    logic [31:0] iss_in_a;
    logic [31:0] iss_in_b;
    logic [4:0]  iss_rob_idx;
    logic [5:0]  iss_pd;

    int n_checks = 0;
    int n_pass = 0;

    alu_reservation_station #(.DEPTH(8), .TAG_W(6), .ROB_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_alu_op  (disp_alu_op),
        .disp_bypass  (disp_bypass),
        .disp_rob_idx (disp_rob_idx),
        .disp_pd      (disp_pd),
        .disp_s1_rdy  (disp_s1_rdy),
        .disp_s1_tag  (disp_s1_tag),
        .disp_s1_val  (disp_s1_val),
        .disp_s2_rdy  (disp_s2_rdy),
        .disp_s2_tag  (disp_s2_tag),
        .disp_s2_val  (disp_s2_val),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .iss_valid    (iss_valid),
        .iss_ready    (iss_ready),
        .iss_alu_op   (iss_alu_op),
        .iss_bypass   (iss_bypass),
        .iss_in_a     (iss_in_a),
        .iss_in_b     (iss_in_b),
        .iss_rob_idx  (iss_rob_idx),
        .iss_pd       (iss_pd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model entry; the queue order itself is the age order.
    typedef struct {
        logic [3:0]  op;
        logic        byp;
        logic [4:0]  rob;
        logic [5:0]  pd;
        logic        r1;
        logic [5:0]  t1;
        logic [31:0] v1;
        logic        r2;
        logic [5:0]  t2;
        logic [31:0] v2;
    } ent_t;

    ent_t q[$];

    always @(negedge clk) begin
        int   sel;
        logic exp_valid;
        logic can_disp;
        ent_t e;
        if (rst) begin
            q.delete();
        end else begin
            sel = -1;
            for (int k = 0; k < q.size(); k++)
                if (sel < 0 && q[k].r1 && q[k].r2) sel = k;
            exp_valid = (sel >= 0) && !flush;
            can_disp  = q.size() < DEPTH;
            check("m_disp_ready", {31'd0, disp_ready}, {31'd0, can_disp});
            check("m_iss_valid", {31'd0, iss_valid}, {31'd0, exp_valid});
            if (exp_valid) begin
                check("m_op", {28'd0, iss_alu_op}, {28'd0, q[sel].op});
                check("m_bypass", {31'd0, iss_bypass}, {31'd0, q[sel].byp});
                check("m_in_a", iss_in_a, q[sel].v1);
                check("m_in_b", iss_in_b, q[sel].v2);
                check("m_rob", {27'd0, iss_rob_idx}, {27'd0, q[sel].rob});
                check("m_pd", {26'd0, iss_pd}, {26'd0, q[sel].pd});
            end
            if (flush) begin
                q.delete();
            end else begin
                if (cdb_valid) begin
                    for (int k = 0; k < q.size(); k++) begin
                        e = q[k];
                        if (!e.r1 && e.t1 == cdb_tag) begin e.r1 = 1'b1; e.v1 = cdb_data; end
                        if (!e.r2 && e.t2 == cdb_tag) begin e.r2 = 1'b1; e.v2 = cdb_data; end
                        q[k] = e;
                    end
                end
                if (exp_valid && iss_ready) q.delete(sel);
                if (disp_valid && can_disp) begin
                    e.op  = disp_alu_op;
                    e.byp = disp_bypass;
                    e.rob = disp_rob_idx;
                    e.pd  = disp_pd;
                    e.r1  = disp_s1_rdy;
                    e.t1  = disp_s1_tag;
                    e.v1  = disp_s1_val;
                    e.r2  = disp_s2_rdy;
                    e.t2  = disp_s2_tag;
                    e.v2  = disp_s2_val;
                    if (cdb_valid && !e.r1 && e.t1 == cdb_tag) begin e.r1 = 1'b1; e.v1 = cdb_data; end
                    if (cdb_valid && !e.r2 && e.t2 == cdb_tag) begin e.r2 = 1'b1; e.v2 = cdb_data; end
                    q.push_back(e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic drive_disp(input logic [3:0] op, input logic byp, input logic [4:0] rob,
                              input logic [5:0] pd, input logic r1, input logic [5:0] t1,
                              input logic [31:0] v1, input logic r2, input logic [5:0] t2,
                              input logic [31:0] v2);
        disp_valid   = 1'b1;
        disp_alu_op  = alu_ops'(op);
        disp_bypass  = byp;
        disp_rob_idx = rob;
        disp_pd      = pd;
        disp_s1_rdy  = r1;
        disp_s1_tag  = t1;
        disp_s1_val  = v1;
        disp_s2_rdy  = r2;
        disp_s2_tag  = t2;
        disp_s2_val  = v2;
    endtask

    task automatic drive_cdb(input logic [5:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
    endtask

    initial begin
        idle();
        iss_ready = 1'b0;
        drive_disp(4'd0, 1'b0, 5'd0, 6'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        disp_valid = 1'b0;
        cdb_tag = '0;
        cdb_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, then a single fully ready add
        #2;
        check("rst_disp_ready", {31'd0, disp_ready}, 32'd1);
        check("rst_iss_valid", {31'd0, iss_valid}, 32'd0);
        iss_ready = 1'b1;
        drive_disp(alu_add, 1'b0, 5'd1, 6'd33, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7);
        cyc(); idle(); #2;
        check("t1_valid", {31'd0, iss_valid}, 32'd1);
        check("t1_in_a", iss_in_a, 32'd5);
        check("t1_in_b", iss_in_b, 32'd7);
        check("t1_op", {28'd0, iss_alu_op}, {28'd0, alu_add});
        cyc(); #2;
        check("t1_empty", {31'd0, iss_valid}, 32'd0);

        // Younger ready op overtakes an older waiting one
        cyc(); drive_disp(alu_sub, 1'b0, 5'd1, 6'd40, 1'b0, 6'd3, 32'd0, 1'b1, 6'd0, 32'd9);
        cyc(); drive_disp(alu_or, 1'b0, 5'd2, 6'd41, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 32'd3);
        #2 check("t2_a_waits", {31'd0, iss_valid}, 32'd0);
        cyc(); idle(); drive_cdb(6'd3, 32'h10); #2;
        check("t2_b_first", {27'd0, iss_rob_idx}, 32'd2);
        cyc(); idle(); #2;
        check("t2_a_second", {27'd0, iss_rob_idx}, 32'd1);
        check("t2_a_in_a", iss_in_a, 32'h10);
        cyc(); #2 check("t2_empty", {31'd0, iss_valid}, 32'd0);

        // Wakeup on the dispatch cycle
        cyc();
        drive_disp(alu_xor, 1'b1, 5'd3, 6'd42, 1'b1, 6'd0, 32'd4, 1'b0, 6'd9, 32'd0);
        drive_cdb(6'd9, 32'hDEAD);
        cyc(); idle(); #2;
        check("t3_valid", {31'd0, iss_valid}, 32'd1);
        check("t3_in_b", iss_in_b, 32'hDEAD);
        cyc();

        // Fill to full with nothing ready
        iss_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            drive_disp(alu_and, 1'b0, 5'(i), 6'(i), 1'b0, 6'(10 + i), 32'd0, 1'b1, 6'd0, 32'(i));
        end
        cyc();
        drive_disp(alu_add, 1'b0, 5'd31, 6'd50, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
        #2;
        check("t4_full", {31'd0, disp_ready}, 32'd0);
        check("t4_stall", {31'd0, iss_valid}, 32'd0);
        cyc(); idle(); #2 check("t4_dropped", {31'd0, iss_valid}, 32'd0);
        drive_cdb(6'd10, 32'h1234);
        cyc(); idle(); iss_ready = 1'b1; #2;
        check("t4_woke", {31'd0, iss_valid}, 32'd1);
        check("t4_rob", {27'd0, iss_rob_idx}, 32'd0);
        check("t4_in_a", iss_in_a, 32'h1234);
        check("t4_still_full", {31'd0, disp_ready}, 32'd0);
        cyc(); #2 check("t4_freed", {31'd0, disp_ready}, 32'd1);
        for (int t = 11; t < 18; t++) begin
            drive_cdb(6'(t), 32'(t));
            cyc(); idle();
        end
        repeat (3) cyc();

        // Held issue port keeps the oldest, then drains in dispatch order
        iss_ready = 1'b0;
        drive_disp(alu_add, 1'b0, 5'd5, 6'd5, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2);
        cyc(); drive_disp(alu_sub, 1'b0, 5'd6, 6'd6, 1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 32'd4);
        cyc(); drive_disp(alu_sll, 1'b0, 5'd7, 6'd7, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd6);
        cyc(); idle(); #2 check("t5_hold0", {27'd0, iss_rob_idx}, 32'd5);
        cyc(); #2 check("t5_hold1", {27'd0, iss_rob_idx}, 32'd5);
        iss_ready = 1'b1;
        cyc(); #2 check("t5_second", {27'd0, iss_rob_idx}, 32'd6);
        cyc(); #2 check("t5_third", {27'd0, iss_rob_idx}, 32'd7);
        cyc(); #2 check("t5_empty", {31'd0, iss_valid}, 32'd0);

        // Flush with live entries and a concurrent dispatch
        iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            drive_disp(alu_or, 1'b0, 5'(20 + i), 6'(20 + i), (i < 2), 6'(20 + i), 32'(i),
                       1'b1, 6'd0, 32'd0);
        end
        cyc(); idle(); flush = 1'b1;
        drive_disp(alu_add, 1'b0, 5'd30, 6'd30, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
        #2 check("t6_flush_iss", {31'd0, iss_valid}, 32'd0);
        cyc(); idle(); #2;
        check("t6_after_ready", {31'd0, disp_ready}, 32'd1);
        check("t6_after_valid", {31'd0, iss_valid}, 32'd0);
        cyc(); #2 check("t6_drop", {31'd0, iss_valid}, 32'd0);

        // Asynchronous reset mid-cycle
        drive_disp(alu_add, 1'b0, 5'd9, 6'd9, 1'b1, 6'd0, 32'd8, 1'b1, 6'd0, 32'd8);
        cyc(); idle(); #2;
        check("t6_pre_rst", {31'd0, iss_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_async_valid", {31'd0, iss_valid}, 32'd0);
        check("t6_async_ready", {31'd0, disp_ready}, 32'd1);
        cyc(); rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(); idle();
            iss_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1)
                drive_disp(4'($urandom_range(0, 9)), 1'($urandom), 5'($urandom), 6'($urandom),
                           1'($urandom), 6'($urandom_range(0, 7)), $urandom,
                           1'($urandom), 6'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 2) == 0)
                drive_cdb(6'($urandom_range(0, 7)), $urandom);
            flush = ($urandom_range(0, 99) == 0);
        end
        cyc(); idle();
        repeat (2) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
